// File: rtl/alu_issue_ctrl.sv
// Issue stage for the 16-bit ALU: buffers commands, drives ALU operands from registers, returns results on a valid/ready port.
// Latency: command pushed into an empty idle block at edge N issues at N+1, result valid after N+2; one result per 2 cycles sustained.
// Backpressure: cmd_ready drops at DEPTH queued commands; a held result (res_ready low) stalls further issue.
// Optional macro ALU_ILLEGAL_OPC_EN: opcode all-ones is not issued and returns a zero result with res_err set.
module alu_issue_ctrl #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int OPC_W = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [OPC_W-1:0]           cmd_opc,
    input  logic [WIDTH-1:0]           cmd_a,
    input  logic [WIDTH-1:0]           cmd_b,
    input  logic                       cmd_c,
    input  logic                       cmd_use_acc,
    output logic [OPC_W-1:0]           alu_opc,
    output logic [WIDTH-1:0]           alu_inA,
    output logic [WIDTH-1:0]           alu_inB,
    output logic                       alu_inC,
    input  logic [WIDTH-1:0]           alu_outW,
    input  logic                       alu_zer,
    input  logic                       alu_neg,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [WIDTH-1:0]           res_data,
    output logic                       res_zer,
    output logic                       res_neg,
    output logic                       res_err,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    typedef struct packed {
        logic [OPC_W-1:0] opc;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             c;
        logic             use_acc;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RESULT = 2'd2
    } state_t;

    cmd_t             fifo_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    cmd_t             push_dat;
    cmd_t             head_dat;
    logic             push_vld;
    logic             pop_vld;
    logic             fifo_empty;
    logic             head_illegal;

    state_t           state;
    state_t           state_nxt;
    logic             issue_ld;
    logic             err_ld;
    logic             capture;
    logic             consume;
    logic [WIDTH-1:0] acc;

    // cmd_ready looks only at current occupancy, never at a same-cycle pop
    assign cmd_ready  = (count < CNT_W'(DEPTH));
    assign push_vld   = cmd_valid && cmd_ready;
    assign fifo_empty = (count == '0);
    assign busy       = (state != IDLE) || !fifo_empty;
    assign head_dat   = fifo_mem[rd_ptr];

    assign push_dat.opc     = cmd_opc;
    assign push_dat.a       = cmd_a;
    assign push_dat.b       = cmd_b;
    assign push_dat.c       = cmd_c;
    assign push_dat.use_acc = cmd_use_acc;

`ifdef ALU_ILLEGAL_OPC_EN
    assign head_illegal = (head_dat.opc == {OPC_W{1'b1}});
`else
    assign head_illegal = 1'b0;
`endif

    // Command storage; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (push_vld) begin
            fifo_mem[wr_ptr] <= push_dat;
        end
    end

    // FIFO pointers wrap naturally at power-of-two DEPTH; count tracks occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_vld) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_vld, pop_vld})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: an illegal head bypasses the ALU cycle straight into RESULT
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    state_nxt = head_illegal ? RESULT : ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = RESULT;
            end
            RESULT: begin
                if (res_ready) begin
                    if (!fifo_empty) begin
                        state_nxt = head_illegal ? RESULT : ISSUE;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: pop/load/capture strobes for the datapath registers
    always_comb begin
        pop_vld  = 1'b0;
        capture  = 1'b0;
        consume  = 1'b0;
        case (state)
            IDLE:    pop_vld = !fifo_empty;
            ISSUE:   capture = 1'b1;
            RESULT: begin
                consume = res_ready;
                pop_vld = res_ready && !fifo_empty;
            end
            default: pop_vld = 1'b0;
        endcase
        issue_ld = pop_vld && !head_illegal;
        err_ld   = pop_vld && head_illegal;
    end

    // ALU operand registers: loaded at pop, held otherwise; use_acc swaps in the accumulator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_opc <= '0;
            alu_inA <= '0;
            alu_inB <= '0;
            alu_inC <= 1'b0;
        end else if (issue_ld) begin
            alu_opc <= head_dat.opc;
            alu_inA <= head_dat.use_acc ? acc : head_dat.a;
            alu_inB <= head_dat.b;
            alu_inC <= head_dat.c;
        end
    end

    // Result capture and accumulator; accumulator updates at capture so the next pop sees it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_zer   <= 1'b0;
            res_neg   <= 1'b0;
            res_err   <= 1'b0;
        end else if (capture) begin
            acc       <= alu_outW;
            res_valid <= 1'b1;
            res_data  <= alu_outW;
            res_zer   <= alu_zer;
            res_neg   <= alu_neg;
            res_err   <= 1'b0;
        end else if (err_ld) begin
            res_valid <= 1'b1;
            res_data  <= '0;
            res_zer   <= 1'b0;
            res_neg   <= 1'b0;
            res_err   <= 1'b1;
        end else if (consume) begin
            res_valid <= 1'b0;
            res_err   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU on the operand pins, scoreboard of expected results.
// Latency: n/a.
// Backpressure: res_ready is driven by the bench, sometimes randomly.
module tb_alu_issue_ctrl;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int OPC_W = 3;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [OPC_W-1:0] cmd_opc;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic             cmd_c;
    logic             cmd_use_acc;
    logic [OPC_W-1:0] alu_opc;
    logic [WIDTH-1:0] alu_inA;
    logic [WIDTH-1:0] alu_inB;
    logic             alu_inC;
    logic [WIDTH-1:0] alu_outW;
    logic             alu_zer;
    logic             alu_neg;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_zer;
    logic             res_neg;
    logic             res_err;
    logic             busy;
    logic [CNT_W-1:0] count;

    alu_issue_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .OPC_W(OPC_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opc(cmd_opc),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_c(cmd_c), .cmd_use_acc(cmd_use_acc),
        .alu_opc(alu_opc), .alu_inA(alu_inA), .alu_inB(alu_inB), .alu_inC(alu_inC),
        .alu_outW(alu_outW), .alu_zer(alu_zer), .alu_neg(alu_neg),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_zer(res_zer), .res_neg(res_neg), .res_err(res_err),
        .busy(busy), .count(count)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: opcode 0 is add with carry
    function automatic logic [15:0] alu_fn(input logic [2:0] op, input logic [15:0] a,
                                           input logic [15:0] b, input logic c);
        case (op)
            3'd0:    return a + b + {15'd0, c};
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return ~a;
            3'd6:    return {a[14:0], c};
            default: return b ^ 16'h5a5a;
        endcase
    endfunction

    assign alu_outW = alu_fn(alu_opc, alu_inA, alu_inB, alu_inC);
    assign alu_zer  = (alu_outW == 16'd0);
    assign alu_neg  = alu_outW[15];

    typedef struct packed {
        logic [15:0] d;
        logic        z;
        logic        n;
        logic        e;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] got_q[$];
    int          hs_cyc[$];
    logic [15:0] acc_m = 16'd0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: each accepted command produces its expected result in order
    always @(negedge clk) begin
        if (rst_n && cmd_valid && cmd_ready) begin
            exp_t        e;
            logic        ill;
            logic [15:0] r;
            ill = 1'b0;
`ifdef ALU_ILLEGAL_OPC_EN
            ill = (cmd_opc == 3'b111);
`endif
            if (ill) begin
                e = '{d: 16'd0, z: 1'b0, n: 1'b0, e: 1'b1};
            end else begin
                r = alu_fn(cmd_opc, cmd_use_acc ? acc_m : cmd_a, cmd_b, cmd_c);
                acc_m = r;
                e = '{d: r, z: (r == 16'd0), n: r[15], e: 1'b0};
            end
            exp_q.push_back(e);
        end
    end

    // Monitor: every result handshake is compared against the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_result: got %0h, expected no result", res_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("res_data", 32'(res_data), 32'(e.d));
                check("res_zer", 32'(res_zer), 32'(e.z));
                check("res_neg", 32'(res_neg), 32'(e.n));
                check("res_err", 32'(res_err), 32'(e.e));
            end
            got_q.push_back(res_data);
            hs_cyc.push_back(cyc);
        end
    end

    task automatic drive_cmd(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                             input logic c, input logic ua);
        cmd_valid   = 1'b1;
        cmd_opc     = op;
        cmd_a       = a;
        cmd_b       = b;
        cmd_c       = c;
        cmd_use_acc = ua;
    endtask

    task automatic wait_drain();
        int k = 0;
        while ((exp_q.size() != 0 || busy || res_valid) && k < 500) begin
            @(posedge clk); #1;
            k++;
        end
        check("drain_pending", 32'(exp_q.size()), 32'd0);
        check("drain_busy", 32'(busy), 32'd0);
    endtask

    task automatic rand_phase(input int npush);
        int got = 0;
        int k = 0;
        while (got < npush && k < 3000) begin
            @(posedge clk); #1;
            res_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) != 0)
                drive_cmd(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else
                cmd_valid = 1'b0;
            @(negedge clk);
            if (cmd_valid && cmd_ready) got++;
            k++;
        end
        check("rand_pushes", 32'(got), 32'(npush));
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        wait_drain();
    endtask

    task automatic fill_five();
        for (int i = 0; i < 5; i++) begin
            drive_cmd(3'($urandom_range(0, 6)), 16'h1000 + 16'(i), 16'($urandom), 1'b0, 1'b0);
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_opc = '0; cmd_a = '0; cmd_b = '0; cmd_c = 1'b0; cmd_use_acc = 1'b0;
        res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_alu_inA", 32'(alu_inA), 32'd0);
        check("rst_res_data", 32'(res_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("rel_cmd_ready", 32'(cmd_ready), 32'd1);

        // Single op latency: push at edge N, operands after N+1, result after N+2
        res_ready = 1'b1;
        drive_cmd(3'd0, 16'h0003, 16'h0004, 1'b0, 1'b0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("lat_n0_valid", 32'(res_valid), 32'd0);
        @(posedge clk); #1;
        check("lat_alu_opc", 32'(alu_opc), 32'd0);
        check("lat_alu_inA", 32'(alu_inA), 32'h0003);
        check("lat_alu_inB", 32'(alu_inB), 32'h0004);
        check("lat_n1_valid", 32'(res_valid), 32'd0);
        @(posedge clk); #1;
        check("lat_n2_valid", 32'(res_valid), 32'd1);
        check("lat_n2_data", 32'(res_data), 32'h0007);
        wait_drain();

        // Fill and back-pressure, then release and check 2-cycle cadence
        res_ready = 1'b0;
        fill_five();
        check("full_count", 32'(count), 32'd4);
        check("full_cmd_ready", 32'(cmd_ready), 32'd0);
        check("full_res_valid", 32'(res_valid), 32'd1);
        drive_cmd(3'd1, 16'hdead, 16'hbeef, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("refuse_cmd_ready", 32'(cmd_ready), 32'd0);
            check("refuse_count", 32'(count), 32'd4);
            check("held_res_data", 32'(res_data), 32'(exp_q[0].d));
        end
        cmd_valid = 1'b0;
        base = hs_cyc.size();
        res_ready = 1'b1;
        wait_drain();
        check("bp_results", 32'(hs_cyc.size() - base), 32'd5);
        for (int i = base + 1; i < hs_cyc.size(); i++)
            check("bp_cadence", 32'(hs_cyc[i] - hs_cyc[i-1]), 32'd2);

        // Reset mid-flight: ISSUE with three entries queued
        res_ready = 1'b0;
        fill_five();
        res_ready = 1'b1;
        @(posedge clk); #1;
        check("pre_rst_count", 32'(count), 32'd3);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        acc_m = 16'd0;
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_res_valid", 32'(res_valid), 32'd0);
        check("midrst_alu_inA", 32'(alu_inA), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("midrst_cmd_ready", 32'(cmd_ready), 32'd1);

        // Accumulator chain and flag corners
        got_q.delete();
        drive_cmd(3'd0, 16'h0001, 16'h0000, 1'b0, 1'b0);
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            drive_cmd(3'd0, 16'hffff, 16'h0001, 1'b0, 1'b1);
            @(posedge clk); #1;
        end
        drive_cmd(3'd0, 16'h7fff, 16'h0001, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive_cmd(3'd0, 16'hffff, 16'h0001, 1'b0, 1'b0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wait_drain();
        check("chain_n", 32'(got_q.size()), 32'd6);
        if (got_q.size() == 6) begin
            check("chain_0", 32'(got_q[0]), 32'h0001);
            check("chain_1", 32'(got_q[1]), 32'h0002);
            check("chain_2", 32'(got_q[2]), 32'h0003);
            check("chain_3", 32'(got_q[3]), 32'h0004);
            check("chain_neg", 32'(got_q[4]), 32'h8000);
            check("chain_zero", 32'(got_q[5]), 32'h0000);
        end

        // Opcode all-ones between two legal ops
        drive_cmd(3'd0, 16'h0005, 16'h0006, 1'b0, 1'b0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wait_drain();
        drive_cmd(3'd7, 16'h1234, 16'h00ff, 1'b0, 1'b0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
`ifdef ALU_ILLEGAL_OPC_EN
        check("ill_res_valid", 32'(res_valid), 32'd1);
        check("ill_res_err", 32'(res_err), 32'd1);
        check("ill_res_data", 32'(res_data), 32'd0);
        check("ill_alu_opc", 32'(alu_opc), 32'd0);
        check("ill_alu_inA", 32'(alu_inA), 32'h0005);
`else
        check("op7_res_valid_n1", 32'(res_valid), 32'd0);
        check("op7_alu_opc", 32'(alu_opc), 32'd7);
        check("op7_alu_inA", 32'(alu_inA), 32'h1234);
        @(posedge clk); #1;
        check("op7_res_valid", 32'(res_valid), 32'd1);
        check("op7_res_err", 32'(res_err), 32'd0);
        check("op7_res_data", 32'(res_data), 32'h5aa5);
`endif
        drive_cmd(3'd0, 16'h0000, 16'h0001, 1'b0, 1'b1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wait_drain();

        // Wrap-around with a short run, then a longer random run
        rand_phase(10);
        rand_phase(60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Upstream issue stage for the 16-bit ALU (opc[2:0], inA, inB, inC -> outW, zer, neg).
- Buffers operation commands in a small FIFO and drives the ALU operand pins from registers.
- Captures the ALU result and flags one cycle after issue.
- Presents them through a valid/ready result port, with an accumulator that allows chained operations.

Parameters:
- WIDTH, 16: operand/result width; must equal the ALU width.
- DEPTH, 4: command FIFO entries; power of 2, at least 2.
- OPC_W, 3: opcode width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO can accept; equals (count < DEPTH)
- cmd_opc  in  OPC_W  ALU opcode
- cmd_a  in  WIDTH  operand A
- cmd_b  in  WIDTH  operand B
- cmd_c  in  1  carry-in
- cmd_use_acc  in  1  replace operand A with the accumulator value at pop time
- alu_opc  out  OPC_W  registered, to ALU opc
- alu_inA  out  WIDTH  registered, to ALU inA
- alu_inB  out  WIDTH  registered, to ALU inB
- alu_inC  out  1  registered, to ALU inC
- alu_outW  in  WIDTH  ALU result
- alu_zer  in  1  ALU zero flag
- alu_neg  in  1  ALU negative flag
- res_valid  out  1  result held
- res_ready  in  1  consumer accepts result
- res_data  out  WIDTH  captured result
- res_zer  out  1  captured zero flag
- res_neg  out  1  captured negative flag
- res_err  out  1  illegal-op marker; constant 0 unless ALU_ILLEGAL_OPC_EN is defined
- busy  out  1  high when FSM is not IDLE or FIFO is non-empty
- count  out  $clog2(DEPTH+1)  FIFO occupancy

Behaviour:
- Reset (async, rst_n=0), effective immediately and mid-operation:
  - FIFO emptied, pointers 0, count 0.
  - FSM to IDLE; accumulator 0.
  - All alu_* and res_* outputs 0.
  - cmd_ready=1 once reset is released.
- FIFO push: cmd_valid && cmd_ready at an edge.
  - Pointers wrap modulo DEPTH.
  - Simultaneous push and pop leaves count unchanged.
  - cmd_ready does not anticipate a same-cycle pop: at count==DEPTH it is 0 even if a pop occurs.
- FSM states:
  - IDLE: if FIFO non-empty at an edge, pop the head, load alu_* registers, go to ISSUE.
    - alu_inA = accumulator if cmd_use_acc, else cmd_a.
  - ISSUE: alu_* held stable for the whole cycle. At the next edge:
    - capture alu_outW/zer/neg into res_data/res_zer/res_neg;
    - accumulator <= alu_outW;
    - res_valid <= 1; go to RESULT.
  - RESULT: res_* held stable while res_valid && !res_ready.
    - On an edge with res_ready: res_valid <= 0.
    - If the FIFO is non-empty, pop the next command in the same edge and go to ISSUE; otherwise go to IDLE.
- alu_* keep their last values outside ISSUE.
- Latency: a command pushed into an empty FIFO in IDLE at edge N is issued at edge N+1, and res_valid rises after edge N+2.
- Sustained throughput: one result per 2 cycles with res_ready tied high.
- Accumulator chaining: the accumulator updates at capture, before the next pop, so back-to-back use_acc commands see the previous result.
- Arithmetic is performed entirely in the ALU; this block does no width extension and no flag recomputation.

Optional Feature:
- Macro: ALU_ILLEGAL_OPC_EN.
- Defined: a popped command with opc == all-ones (3'b111) is not issued.
  - FSM goes directly to RESULT at the pop edge, skipping the ALU cycle.
  - Result: res_data=0, res_zer=0, res_neg=0, res_err=1; accumulator unchanged; alu_* unchanged.
  - res_err clears when that result is consumed.
  - All other opcodes behave normally with res_err=0.
- Undefined: opc 3'b111 is issued like any other opcode, and res_err is constant 0.

Test Plan:
- Reset mid-flight: assert rst_n=0 while in ISSUE with 3 FIFO entries -> immediately count=0, res_valid=0, alu_inA=0, busy=0; cmd_ready=1 after release.
- Single op: push opc=3'b000, a=16'h0003, b=16'h0004, c=0 at edge N, ALU model returns 16'h0007 -> alu_* valid after N+1, res_valid=1 after N+2, res_data=16'h0007, zer=0, neg=0.
- Fill and back-pressure: hold res_ready=0 and push 5 commands -> result 1 held stable, FIFO accepts 4 more with count=4 and cmd_ready=0, 6th push refused; release res_ready -> 5 results in push order, 2 cycles apart.
- Accumulator chain: push a=16'h0001 then use_acc with b=16'h0001 three times, with ALU modelled as add -> results 1,2,3,4; ALU returning 16'h8000 -> res_neg=1; returning 0 -> res_zer=1.
- Wrap-around: 10 push/pop pairs with DEPTH=4 -> pointers wrap, and no data lost or duplicated against a scoreboard.
- With ALU_ILLEGAL_OPC_EN: push opc=3'b111 between two legal ops -> res_valid one cycle after the pop, res_err=1, data=0, accumulator unchanged, no alu_* change; without the macro the ALU output is captured and res_err=0.
